// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline hazard and trap sequencer for a two-stage (DE / MW) RISC-V style
// core. Detects load-use hazards, stalls on slow data memory (with a sticky
// timeout), redirects the PC for taken branches, interrupts and MRET, and
// drains the MW stage before an interrupt is taken.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   inst_de      : instruction in the decode/execute stage
//   inst_mw      : instruction in the memory/writeback stage
//   reg_wr_mw    : MW stage writes the register file
//   br_taken     : DE-stage branch/jump resolved taken
//   is_mret      : DE stage holds MRET
//   irq_pending  : interrupt pending (level)
//   irq_enable   : mstatus.MIE
//   mem_ready    : data memory completed the MW access this cycle
//   stall_if     : hold PC and IF/DE register
//   stall_de     : hold DE/MW register
//   flush_de     : replace DE instruction with NOP
//   bubble_mw    : inject NOP into MW next cycle
//   pc_sel       : next PC: 00 PC+4, 01 branch target, 10 mtvec, 11 mepc
//   epc_save     : write DE-stage PC into mepc and clear MIE
//   trap_ack     : interrupt taken (1-cycle pulse)
//   mem_timeout  : sticky memory timeout flag
//   state        : current FSM state (debug)
// -----------------------------------------------------------------------------
module hazard_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_de,
  input  logic [31:0] inst_mw,
  input  logic        reg_wr_mw,
  input  logic        br_taken,
  input  logic        is_mret,
  input  logic        irq_pending,
  input  logic        irq_enable,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_de,
  output logic        flush_de,
  output logic        bubble_mw,
  output logic [1:0]  pc_sel,
  output logic        epc_save,
  output logic        trap_ack,
  output logic        mem_timeout,
  output logic [2:0]  state
);

  localparam logic [2:0] S_RUN        = 3'd0;
  localparam logic [2:0] S_MEM_WAIT   = 3'd1;
  localparam logic [2:0] S_LD_USE     = 3'd2;
  localparam logic [2:0] S_TRAP_DRAIN = 3'd3;
  localparam logic [2:0] S_TRAP_JUMP  = 3'd4;
  localparam logic [2:0] S_MRET_JUMP  = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_MTVEC  = 2'b10;
  localparam logic [1:0] PC_MEPC   = 2'b11;

  // Last counter value before the increment that reaches 15.
  localparam logic [3:0] WAIT_LAST = 4'd14;

  logic [2:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  // Instruction field decode.
  logic [6:0] op_de, op_mw;
  logic [4:0] rs1_de, rs2_de, rd_mw;
  logic       uses_rs1, uses_rs2;
  logic       load_use, mem_busy, irq_take;

  // Fields of the instruction words this block never looks at.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_de[31:25], inst_de[14:7], inst_mw[31:12]};

  assign op_de  = inst_de[6:0];
  assign rs1_de = inst_de[19:15];
  assign rs2_de = inst_de[24:20];
  assign op_mw  = inst_mw[6:0];
  assign rd_mw  = inst_mw[11:7];

  assign uses_rs1 = (op_de == OP_ALU_R) || (op_de == OP_ALU_I) || (op_de == OP_LOAD) ||
                    (op_de == OP_STORE) || (op_de == OP_BRANCH);
  assign uses_rs2 = (op_de == OP_ALU_R) || (op_de == OP_STORE) || (op_de == OP_BRANCH);

  // x0 is never a real dependency, so a load targeting it cannot cause a hazard.
  assign load_use = (op_mw == OP_LOAD) && reg_wr_mw && (rd_mw != 5'd0) &&
                    ((uses_rs1 && (rs1_de == rd_mw)) || (uses_rs2 && (rs2_de == rd_mw)));

  assign mem_busy = ((op_mw == OP_LOAD) || (op_mw == OP_STORE)) && !mem_ready;
  assign irq_take = irq_pending && irq_enable;

  logic       stall_if_c, stall_de_c, flush_de_c, bubble_mw_c;
  logic       epc_save_c, trap_ack_c;
  logic [1:0] pc_sel_c;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves one unassigned (no latches).
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_if_c    = 1'b0;
    stall_de_c    = 1'b0;
    flush_de_c    = 1'b0;
    bubble_mw_c   = 1'b0;
    pc_sel_c      = PC_PLUS4;
    epc_save_c    = 1'b0;
    trap_ack_c    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        wait_cnt_d = 4'd0;
        // The branch redirect is qualified only by the higher-priority events
        // that do not depend on mem_ready, keeping mem_ready off the pc_sel
        // cone. A branch resolved while MW stalls is still taken this cycle.
        if (br_taken && !irq_take && !is_mret) begin
          flush_de_c = 1'b1;
          pc_sel_c   = PC_BRANCH;
        end
        if (irq_take)      state_d = S_TRAP_DRAIN;
        else if (mem_busy) state_d = S_MEM_WAIT;
        else if (is_mret)  state_d = S_MRET_JUMP;
        else if (br_taken) state_d = S_RUN;
        else if (load_use) state_d = S_LD_USE;
      end
      S_MEM_WAIT: begin
        stall_if_c = 1'b1;
        stall_de_c = 1'b1;
        if (mem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Counter would reach 15: give up on the access and flag it.
          state_d       = S_RUN;
          wait_cnt_d    = 4'd0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_LD_USE: begin
        stall_if_c  = 1'b1;
        stall_de_c  = 1'b1;
        bubble_mw_c = 1'b1;
        state_d     = S_RUN;
      end
      S_TRAP_DRAIN: begin
        // Let the MW instruction retire before the trap redirects fetch.
        stall_if_c = 1'b1;
        state_d    = S_TRAP_JUMP;
      end
      S_TRAP_JUMP: begin
        pc_sel_c   = PC_MTVEC;
        epc_save_c = 1'b1;
        trap_ack_c = 1'b1;
        flush_de_c = 1'b1;
        state_d    = S_RUN;
      end
      S_MRET_JUMP: begin
        pc_sel_c   = PC_MEPC;
        flush_de_c = 1'b1;
        state_d    = S_RUN;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= 4'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Outputs are gated by rst_n so they read 0 during reset even though the
  // RUN-state branch redirect is combinational from br_taken.
  assign stall_if    = rst_n & stall_if_c;
  assign stall_de    = rst_n & stall_de_c;
  assign flush_de    = rst_n & flush_de_c;
  assign bubble_mw   = rst_n & bubble_mw_c;
  assign pc_sel      = rst_n ? pc_sel_c : PC_PLUS4;
  assign epc_save    = rst_n & epc_save_c;
  assign trap_ack    = rst_n & trap_ack_c;
  assign mem_timeout = rst_n & mem_timeout_q;
  assign state       = rst_n ? state_q : S_RUN;

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// Directed bench for hazard_sequencer. A driver applies one row of inputs per
// cycle just after the rising edge and queues the hand-computed outputs for
// that cycle; an independent monitor pops the queue on the falling edge and
// compares against the DUT.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       timeout;
    logic       ack;
    logic       epc;
    logic [1:0] pcs;
    logic       bub;
    logic       fl;
    logic       sde;
    logic       sif;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  localparam logic [31:0] NOP     = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] LW5     = 32'h0000_a283; // lw   x5,0(x1)
  localparam logic [31:0] LW0     = 32'h0000_a003; // lw   x0,0(x1)
  localparam logic [31:0] SW5     = 32'h0050_a023; // sw   x5,0(x1)
  localparam logic [31:0] ADD_RS1 = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] ADD_RS2 = 32'h0050_8333; // add  x6,x1,x5
  localparam logic [31:0] ADD_X0  = 32'h0020_0333; // add  x6,x0,x2
  localparam logic [31:0] LUI     = 32'h0002_8337; // lui  x6,0x28 (bits 19:15 = 5)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_de = NOP;
  logic [31:0] inst_mw = NOP;
  logic        reg_wr_mw = 1'b0;
  logic        br_taken = 1'b0;
  logic        is_mret = 1'b0;
  logic        irq_pending = 1'b0;
  logic        irq_enable = 1'b0;
  logic        mem_ready = 1'b1;
  logic        stall_if, stall_de, flush_de, bubble_mw, epc_save, trap_ack, mem_timeout;
  logic [1:0]  pc_sel;
  logic [2:0]  dut_state;

  int checks = 0;
  int errors = 0;
  item_t q[$];
  item_t cur;
  exp_t  got;

  hazard_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_de    (inst_de),
    .inst_mw    (inst_mw),
    .reg_wr_mw  (reg_wr_mw),
    .br_taken   (br_taken),
    .is_mret    (is_mret),
    .irq_pending(irq_pending),
    .irq_enable (irq_enable),
    .mem_ready  (mem_ready),
    .stall_if   (stall_if),
    .stall_de   (stall_de),
    .flush_de   (flush_de),
    .bubble_mw  (bubble_mw),
    .pc_sel     (pc_sel),
    .epc_save   (epc_save),
    .trap_ack   (trap_ack),
    .mem_timeout(mem_timeout),
    .state      (dut_state)
  );

  always #5 clk = ~clk;

  assign got = {dut_state, mem_timeout, trap_ack, epc_save, pc_sel,
                bubble_mw, flush_de, stall_de, stall_if};

  function automatic exp_t ex(input logic [2:0] st, input logic sif, input logic sde,
                              input logic fl, input logic bub, input logic [1:0] pcs,
                              input logic epc, input logic ack, input logic to);
    exp_t r;
    r.st = st; r.sif = sif; r.sde = sde; r.fl = fl; r.bub = bub;
    r.pcs = pcs; r.epc = epc; r.ack = ack; r.timeout = to;
    return r;
  endfunction

  // RUN with every output quiet.
  function automatic exp_t z(input logic to);
    return ex(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, to);
  endfunction

  task automatic check(input string nm, input exp_t actual, input exp_t want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("FAIL %s got st=%0d to=%b ack=%b epc=%b pc=%b bub=%b fl=%b sde=%b sif=%b want st=%0d to=%b ack=%b epc=%b pc=%b bub=%b fl=%b sde=%b sif=%b",
               nm, actual.st, actual.timeout, actual.ack, actual.epc, actual.pcs, actual.bub,
               actual.fl, actual.sde, actual.sif, want.st, want.timeout, want.ack, want.epc,
               want.pcs, want.bub, want.fl, want.sde, want.sif);
    end
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic row(input string nm, input logic rn, input logic [31:0] de,
                     input logic [31:0] mw, input logic rw, input logic br,
                     input logic mret, input logic irq, input logic en,
                     input logic rdy, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    rst_n = rn; inst_de = de; inst_mw = mw; reg_wr_mw = rw; br_taken = br;
    is_mret = mret; irq_pending = irq; irq_enable = en; mem_ready = rdy;
    it.name = nm;
    it.e    = e;
    q.push_back(it);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      check(cur.name, got, cur.e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1);
  end

  initial begin
    //   name              rn de       mw   rw br mr irq en rdy expected
    // Reset holds outputs at 0 even with every request active.
    row("reset_0",         0, ADD_RS1, LW5, 1, 1, 1, 1, 1, 0, z(0));
    row("reset_1",         0, ADD_RS1, LW5, 1, 1, 1, 1, 1, 0, z(0));
    row("idle",            1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // Load-use on rs1, then on rs2.
    row("lu_rs1_detect",   1, ADD_RS1, LW5, 1, 0, 0, 0, 0, 1, z(0));
    row("lu_rs1_stall",    1, ADD_RS1, NOP, 0, 0, 0, 0, 0, 1, ex(3'd2, 1, 1, 0, 1, 2'b00, 0, 0, 0));
    row("lu_rs1_after",    1, ADD_RS1, NOP, 0, 0, 0, 0, 0, 1, z(0));
    row("lu_rs2_detect",   1, ADD_RS2, LW5, 1, 0, 0, 0, 0, 1, z(0));
    row("lu_rs2_stall",    1, ADD_RS2, NOP, 0, 0, 0, 0, 0, 1, ex(3'd2, 1, 1, 0, 1, 2'b00, 0, 0, 0));
    row("lu_rs2_after",    1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // Non-hazards: rd = x0, U-type consumer, load not writing the file.
    row("rd_x0",           1, ADD_X0,  LW0, 1, 0, 0, 0, 0, 1, z(0));
    row("rd_x0_next",      1, ADD_X0,  LW0, 1, 0, 0, 0, 0, 1, z(0));
    row("lui_no_rs",       1, LUI,     LW5, 1, 0, 0, 0, 0, 1, z(0));
    row("lui_no_rs_next",  1, LUI,     LW5, 1, 0, 0, 0, 0, 1, z(0));
    row("no_regwr",        1, ADD_RS1, LW5, 0, 0, 0, 0, 0, 1, z(0));
    row("no_regwr_next",   1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // Taken branch redirects combinationally and stays in RUN.
    row("branch",          1, NOP,     NOP, 0, 1, 0, 0, 0, 1, ex(3'd0, 0, 0, 1, 0, 2'b01, 0, 0, 0));
    row("branch_next",     1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // Interrupt pending but disabled is ignored.
    row("irq_masked",      1, NOP,     NOP, 0, 0, 0, 1, 0, 1, z(0));
    row("irq_masked_next", 1, NOP,     NOP, 0, 0, 0, 1, 0, 1, z(0));

    // Load with mem_ready low three cycles: three stall cycles, then RUN.
    row("mw_enter",        1, NOP,     LW5, 1, 0, 0, 0, 0, 0, z(0));
    row("mw_stall_1",      1, NOP,     LW5, 1, 1, 0, 0, 0, 0, ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("mw_stall_2",      1, ADD_RS1, LW5, 1, 0, 1, 0, 0, 0, ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("mw_stall_3",      1, NOP,     LW5, 1, 0, 0, 0, 0, 1, ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("mw_done",         1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // Store also waits on memory.
    row("sw_enter",        1, NOP,     SW5, 0, 0, 0, 0, 0, 0, z(0));
    row("sw_stall",        1, NOP,     SW5, 0, 0, 0, 0, 0, 1, ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("sw_done",         1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // MRET.
    row("mret_detect",     1, NOP,     NOP, 0, 0, 1, 0, 0, 1, z(0));
    row("mret_jump",       1, NOP,     NOP, 0, 0, 0, 0, 0, 1, ex(3'd5, 0, 0, 1, 0, 2'b11, 0, 0, 0));
    row("mret_done",       1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(0));

    // Interrupt beats a simultaneous branch: pc_sel never 01.
    row("irqbr_detect",    1, NOP,     NOP, 0, 1, 0, 1, 1, 1, z(0));
    row("irqbr_drain",     1, NOP,     NOP, 0, 1, 0, 0, 1, 1, ex(3'd3, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    row("irqbr_jump",      1, NOP,     NOP, 0, 1, 0, 0, 1, 1, ex(3'd4, 0, 0, 1, 0, 2'b10, 1, 1, 0));
    row("irqbr_done",      1, NOP,     NOP, 0, 0, 0, 0, 1, 1, z(0));

    // Interrupt raised during MEM_WAIT is deferred until memory completes.
    row("defer_enter",     1, NOP,     LW5, 1, 0, 0, 0, 1, 0, z(0));
    row("defer_wait_1",    1, NOP,     LW5, 1, 0, 0, 1, 1, 0, ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("defer_wait_2",    1, NOP,     LW5, 1, 0, 0, 1, 1, 1, ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("defer_run",       1, NOP,     NOP, 0, 0, 0, 1, 1, 1, z(0));
    row("defer_drain",     1, NOP,     NOP, 0, 0, 0, 0, 1, 1, ex(3'd3, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    row("defer_jump",      1, NOP,     NOP, 0, 0, 0, 0, 1, 1, ex(3'd4, 0, 0, 1, 0, 2'b10, 1, 1, 0));
    row("defer_done",      1, NOP,     NOP, 0, 0, 0, 0, 1, 1, z(0));

    // Memory never answers: 15 wait cycles, then forced RUN with sticky flag.
    row("to_enter",        1, NOP,     LW5, 1, 0, 0, 0, 0, 0, z(0));
    for (int i = 0; i < 15; i++)
      row($sformatf("to_wait_%0d", i), 1, NOP, LW5, 1, 0, 0, 0, 0, 0,
          ex(3'd1, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    row("to_flag",         1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(1));
    row("to_sticky_br",    1, NOP,     NOP, 0, 1, 0, 0, 0, 1, ex(3'd0, 0, 0, 1, 0, 2'b01, 0, 0, 1));
    row("to_sticky",       1, NOP,     NOP, 0, 0, 0, 0, 0, 1, z(1));

    // Reset asserted mid-way through TRAP_DRAIN aborts the trap.
    row("abort_detect",    1, NOP,     NOP, 0, 0, 0, 1, 1, 1, z(1));
    row("abort_drain",     1, NOP,     NOP, 0, 1, 0, 1, 1, 1, ex(3'd3, 1, 0, 0, 0, 2'b00, 0, 0, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_immediate", got, z(0));
    row("abort_held_0",    0, NOP,     NOP, 0, 1, 0, 1, 1, 1, z(0));
    row("abort_held_1",    0, NOP,     NOP, 0, 1, 0, 1, 1, 1, z(0));
    row("abort_rel_0",     1, NOP,     NOP, 0, 0, 0, 0, 1, 1, z(0));
    row("abort_rel_1",     1, NOP,     NOP, 0, 0, 0, 0, 1, 1, z(0));
    row("abort_rel_2",     1, NOP,     NOP, 0, 0, 0, 0, 1, 1, z(0));

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `inst_de`, input, 32 bits: instruction in decode/execute stage.
REQ-004 SHALL have port `inst_mw`, input, 32 bits: instruction in memory/writeback stage.
REQ-005 SHALL have port `reg_wr_mw`, input, 1 bit: MW stage writes the register file.
REQ-006 SHALL have port `br_taken`, input, 1 bit: DE-stage branch/jump resolved taken.
REQ-007 SHALL have port `is_mret`, input, 1 bit: DE stage holds MRET.
REQ-008 SHALL have port `irq_pending`, input, 1 bit: external/timer interrupt pending (level).
REQ-009 SHALL have port `irq_enable`, input, 1 bit: mstatus.MIE.
REQ-010 SHALL have port `mem_ready`, input, 1 bit: data memory completed the MW access this cycle.
REQ-011 SHALL have port `stall_if`, output, 1 bit: hold PC and IF/DE register.
REQ-012 SHALL have port `stall_de`, output, 1 bit: hold DE/MW register.
REQ-013 SHALL have port `flush_de`, output, 1 bit: replace DE instruction with NOP.
REQ-014 SHALL have port `bubble_mw`, output, 1 bit: inject NOP into MW next cycle.
REQ-015 SHALL have port `pc_sel`, output, 2 bits: next-PC source; 00 = PC+4, 01 = branch target, 10 = mtvec, 11 = mepc.
REQ-016 SHALL have port `epc_save`, output, 1 bit: write DE-stage PC into mepc and clear MIE.
REQ-017 SHALL have port `trap_ack`, output, 1 bit: interrupt taken (1-cycle pulse).
REQ-018 SHALL have port `mem_timeout`, output, 1 bit: sticky error flag.
REQ-019 SHALL have port `state`, output, 3 bits: current FSM state, for debug.

Function
REQ-020 SHALL implement the FSM states RUN = 0, MEM_WAIT = 1, LD_USE = 2, TRAP_DRAIN = 3, TRAP_JUMP = 4, MRET_JUMP = 5; codes 6 and 7 SHALL return to RUN on the next edge with all outputs 0.
REQ-021 SHALL define load-use in RUN as all of:
  - inst_mw[6:0] = 0000011, reg_wr_mw = 1, and inst_mw[11:7] ≠ 0;
  - inst_mw[11:7] matches rs1 (inst_de[19:15]) of an R/I-ALU/load/store/branch instruction, or rs2 (inst_de[24:20]) of an R/store/branch instruction.
REQ-022 SHALL define mem_busy as inst_mw[6:0] ∈ {0000011, 0100011} with mem_ready = 0.
REQ-023 SHALL evaluate RUN transitions in strict priority order, with the highest priority first:
  - irq_pending & irq_enable → TRAP_DRAIN;
  - mem_busy → MEM_WAIT;
  - is_mret → MRET_JUMP;
  - br_taken → stay in RUN, with flush_de = 1 and pc_sel = 01 combinationally this cycle;
  - load-use → LD_USE;
  - otherwise → stay in RUN, all outputs 0.
REQ-024 SHALL, in MEM_WAIT, drive stall_if = stall_de = 1, increment a 4-bit wait counter each cycle, and return to RUN on mem_ready = 1 (counter cleared).
REQ-025 SHALL, when the wait counter reaches 15 in MEM_WAIT, set mem_timeout and force a return to RUN; mem_timeout is cleared only by reset.
REQ-026 SHALL defer an interrupt arriving in MEM_WAIT; it is taken from RUN on the first eligible cycle.
REQ-027 SHALL, in LD_USE, drive stall_if = stall_de = 1 and bubble_mw = 1 for exactly 1 cycle, then go to RUN.
REQ-028 SHALL, in TRAP_DRAIN, drive stall_if = 1 for 1 cycle so the MW instruction retires; → TRAP_JUMP.
REQ-029 SHALL, in TRAP_JUMP, drive pc_sel = 10, epc_save = 1, trap_ack = 1, and flush_de = 1 for 1 cycle; → RUN.
REQ-030 SHALL, in MRET_JUMP, drive pc_sel = 11 and flush_de = 1 for 1 cycle; → RUN.
REQ-031 SHALL ignore br_taken, is_mret and load-use in every non-RUN state.
REQ-032 SHALL give an interrupt with a simultaneous br_taken precedence; the branch instruction is flushed and re-executes after MRET.
REQ-033 SHALL drive all outputs as functions of state plus the RUN-state inputs only, with no combinational path from mem_ready to pc_sel.

Reset
REQ-034 SHALL, while rst_n = 0, force state = RUN, wait counter = 0, and mem_timeout = 0, and hold every output at 0 irrespective of inputs.
REQ-035 SHALL, on reset assertion mid-sequence (any state), abort that state immediately; after release the FSM starts in RUN with no pending trap or stall.

Verification
REQ-036 SHALL verify load-use: inst_mw = lw x5,0(x1) with reg_wr_mw = 1 and mem_ready = 1; inst_de = add x6,x5,x2 → 1 cycle with stall_if = stall_de = bubble_mw = 1, state 2, then RUN.
REQ-037 SHALL verify rd = x0: same stimulus as REQ-036 with rd = x0 → no stall, all outputs 0.
REQ-038 SHALL verify memory wait and timeout:
  - load in MW with mem_ready low for 3 cycles → stall_if = stall_de = 1 for 3 cycles, RUN on the 4th;
  - mem_ready held low for 15 cycles → mem_timeout = 1 and sticky.
REQ-039 SHALL verify interrupt over branch: irq_pending = irq_enable = 1 together with br_taken = 1 → TRAP_DRAIN (stall_if = 1), then TRAP_JUMP with pc_sel = 10 and trap_ack = epc_save = flush_de = 1, then RUN; pc_sel is never 01.
REQ-040 SHALL verify interrupt deferral and MRET: interrupt raised during MEM_WAIT → no trap_ack until mem_ready, then the trap sequence; is_mret in RUN → 1 cycle of pc_sel = 11 and flush_de = 1.
REQ-041 SHALL verify reset abort: rst_n asserted while in TRAP_DRAIN → outputs 0 immediately, state = 0, and no trap_ack pulse after release.
